// File: rtl/arb_pkg.sv
// Shared definitions for the 16-requester round-robin arbiter.
package arb_pkg;

  localparam int N_REQ    = 16;
  localparam int IDX_W    = 4;
  localparam int MAX_HOLD = 8;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority picker: finds the first set request at or after ptr (mod 16).
module rr_priority_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             pick_valid,
  output logic [IDX_W-1:0] pick_idx
);

  logic [N_REQ-1:0] rotated;
  logic [IDX_W-1:0] offset;

  // Rotate so ptr lands on bit 0, take the lowest set bit, then undo the rotation.
  always_comb begin
    rotated    = N_REQ'({req, req} >> ptr);
    offset     = '0;
    pick_valid = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        offset     = IDX_W'(i);
        pick_valid = 1'b1;
      end
    end
    pick_idx = ptr + offset;
  end

endmodule

// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter for 16 requesters with registered one-hot and encoded grant.
// Optional feature macro: ARB_HOLD_LIMIT_EN (caps an owner's tenure at MAX_HOLD cycles
// when others are waiting). Default build: owner holds for as long as it requests.
module rr_arbiter_16
  import arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  arb_state_t       state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n;
  logic [N_REQ-1:0] gnt_n;
  logic [IDX_W-1:0] gnt_idx_n;
  logic             gnt_valid_n;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic             take_pick;
  logic             go_idle;

`ifdef ARB_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt, hold_cnt_n;
`endif

  // Since ptr is always owner+1, the owner sits last in search order and
  // the picker naturally prefers any other requester.
  rr_priority_pick u_pick (
    .req       (req),
    .ptr       (ptr),
    .pick_valid(pick_valid),
    .pick_idx  (pick_idx)
  );

  // Decide the next owner: grant, hold, hand over, or go idle.
  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    gnt_n       = gnt;
    gnt_idx_n   = gnt_idx;
    gnt_valid_n = gnt_valid;
    take_pick   = 1'b0;
    go_idle     = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
    hold_cnt_n  = hold_cnt;
`endif
    case (state)
      ARB_IDLE: begin
        if (pick_valid) take_pick = 1'b1;
      end
      ARB_BUSY: begin
        if (!req[gnt_idx]) begin
          if (pick_valid) take_pick = 1'b1;
          else            go_idle   = 1'b1;
        end
`ifdef ARB_HOLD_LIMIT_EN
        else if (hold_cnt == HOLD_LAST) begin
          if (pick_idx != gnt_idx) take_pick  = 1'b1;
          else                     hold_cnt_n = '0;
        end else begin
          hold_cnt_n = hold_cnt + 8'd1;
        end
`endif
      end
      default: go_idle = 1'b1;
    endcase

    if (take_pick) begin
      state_n     = ARB_BUSY;
      gnt_n       = N_REQ'(1) << pick_idx;
      gnt_idx_n   = pick_idx;
      gnt_valid_n = 1'b1;
      ptr_n       = pick_idx + IDX_W'(1);
`ifdef ARB_HOLD_LIMIT_EN
      hold_cnt_n  = '0;
`endif
    end else if (go_idle) begin
      state_n     = ARB_IDLE;
      gnt_n       = '0;
      gnt_idx_n   = '0;
      gnt_valid_n = 1'b0;
    end
  end

  // State, pointer and grant registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      ptr       <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      gnt       <= gnt_n;
      gnt_idx   <= gnt_idx_n;
      gnt_valid <= gnt_valid_n;
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  // Tenure counter for the current owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_cnt <= '0;
    else        hold_cnt <= hold_cnt_n;
  end
`endif

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Scoreboard testbench for rr_arbiter_16 using directed request vectors.
module tb_rr_arbiter_16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] req = 16'hFFFF;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_valid;

  typedef struct {
    int          due;
    logic [15:0] gnt;
    logic [3:0]  idx;
    logic        valid;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  rr_arbiter_16 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Compare one value and record the result.
  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, expv);
    end
  endtask

  // Drive one request vector for one cycle and queue the hand-computed response.
  task automatic applyStimulus(input logic [15:0] r, input logic v, input logic [3:0] idx);
    exp_t e;
    @(posedge clk);
    #1;
    req     = r;
    e.due   = cyc + 1;
    e.valid = v;
    e.idx   = v ? idx : 4'd0;
    e.gnt   = v ? (16'd1 << idx) : 16'd0;
    exp_q.push_back(e);
  endtask

  // Monitor: each cycle, compare DUT outputs against any expectation due now.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.due < cyc) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL stale_expectation: due %0d, now %0d", e.due, cyc);
      end else begin
        checkOutput("gnt", gnt, e.gnt);
        checkOutput("gnt_idx", {12'd0, gnt_idx}, {12'd0, e.idx});
        checkOutput("gnt_valid", {15'd0, gnt_valid}, {15'd0, e.valid});
      end
    end
  end

  initial begin
    // Reset held with every request active: outputs must stay zero.
    repeat (3) @(negedge clk);
    checkOutput("reset_gnt", gnt, 16'h0000);
    checkOutput("reset_idx", {12'd0, gnt_idx}, 16'h0000);
    checkOutput("reset_valid", {15'd0, gnt_valid}, 16'h0000);
    req = 16'h0000;
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(16'h0000, 1'b0, 4'd0);

    // Single requester then release.
    applyStimulus(16'h0010, 1'b1, 4'd4);
    applyStimulus(16'h0000, 1'b0, 4'd0);

    // Reset asserted mid-grant clears outputs without waiting for a clock.
    applyStimulus(16'h0010, 1'b1, 4'd4);
    applyStimulus(16'h0010, 1'b1, 4'd4);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_gnt", gnt, 16'h0000);
    checkOutput("async_rst_idx", {12'd0, gnt_idx}, 16'h0000);
    checkOutput("async_rst_valid", {15'd0, gnt_valid}, 16'h0000);
    req = 16'h0000;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Rotation: all request, each owner drops for one cycle -> 0,1,...,15,0.
    applyStimulus(16'hFFFF, 1'b1, 4'd0);
    for (int k = 0; k < 16; k++)
      applyStimulus(~(16'd1 << k), 1'b1, 4'((k + 1) % 16));
    applyStimulus(16'h0000, 1'b0, 4'd0);

    // Handover: owner 3 leaves as 15 and 0 arrive; ptr=4 so 15 wins, then 0.
    applyStimulus(16'h0008, 1'b1, 4'd3);
    applyStimulus(16'h8001, 1'b1, 4'd15);
    applyStimulus(16'h0001, 1'b1, 4'd0);
    applyStimulus(16'h0000, 1'b0, 4'd0);

    // Hold: owner 0 keeps requesting while 1 waits.
    applyStimulus(16'h0001, 1'b1, 4'd0);
    for (int j = 0; j < 50; j++) begin
`ifdef ARB_HOLD_LIMIT_EN
      applyStimulus(16'h0003, 1'b1, 4'(((j + 1) / 8) % 2));
`else
      applyStimulus(16'h0003, 1'b1, 4'd0);
`endif
    end
    applyStimulus(16'h0002, 1'b1, 4'd1);
    applyStimulus(16'h0000, 1'b0, 4'd0);

    // A lone requester is never preempted.
    for (int j = 0; j < 20; j++)
      applyStimulus(16'h0001, 1'b1, 4'd0);
    applyStimulus(16'h0000, 1'b0, 4'd0);

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
